pipereg_skid: RTL and testbench
===============================

PIPEREG_SKID -- requirements
Module: pipereg_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RST_VAL, default 0, DATA_W-bit value loaded into both data registers at reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_i  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept; driven from a register, not combinationally from out_ready_i.
REQ-007 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-008 SHALL have port out_valid_o  output  1  downstream payload valid.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-010 SHALL have port out_data_o  output  DATA_W  downstream payload, driven from the main register.
REQ-011 SHALL have port flush_i  input  1  synchronous kill of all held and incoming payloads.
REQ-012 SHALL have port occ_o  output  2  entries held (0, 1 or 2).

Function
REQ-013 SHALL treat in_valid_i & in_ready_o as an accept and out_valid_o & out_ready_i as a fire.
REQ-014 SHALL implement states EMPTY (occ 0), FULL (main valid, occ 1) and SKID (main and skid valid, occ 2).
REQ-015 In EMPTY, SHALL go to FULL and load main on accept; otherwise it stays in EMPTY.
REQ-016 In FULL, on accept & fire, SHALL load main and stay in FULL; on accept only, SHALL load skid and go to SKID; on fire only, SHALL go to EMPTY.
REQ-017 In SKID, SHALL hold in_ready_o low; on fire, SHALL copy skid to main and go to FULL.
REQ-018 SHALL assert in_ready_o in EMPTY and FULL only.
REQ-019 SHALL assert out_valid_o in FULL and SKID only.
REQ-020 SHALL give a latency of 1 cycle from accept to out_valid_o and sustain 1 transfer/cycle when out_ready_i is held high.
REQ-021 SHALL hold out_data_o stable while out_valid_o & !out_ready_i; payload order SHALL be preserved.
REQ-022 On flush_i, SHALL go to EMPTY next cycle regardless of state, with priority over accept and fire. A same-cycle input is dropped, and data registers hold their values.
REQ-023 Flush and fire in the same cycle SHALL count as a transfer to downstream; downstream sees the fire.

Reset
REQ-024 While reset_i is low, SHALL force state EMPTY, in_ready_o=1, out_valid_o=0, occ_o=0 and out_data_o=RST_VAL, with the skid register at RST_VAL.
REQ-025 Reset asserted mid-transfer SHALL discard held payloads immediately, without waiting for a clock edge.
REQ-026 SHALL leave reset and accept input on the first rising edge after reset_i goes high.

Configuration
REQ-027 With macro PIPEREG_SKID_PERF_EN defined, SHALL add output ports stall_cnt_o and bubble_cnt_o, each 32 bits.
REQ-028 With PIPEREG_SKID_PERF_EN defined:
- stall_cnt_o SHALL increment each cycle out_valid_o & !out_ready_i.
- bubble_cnt_o SHALL increment each cycle !out_valid_o & out_ready_i.
- Both SHALL reset to 0, SHALL NOT be cleared by flush_i, and SHALL wrap at 2^32.
REQ-029 Without PIPEREG_SKID_PERF_EN, those ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package pipe_pkg SHALL hold:
- the state typedef pipereg_state_t: EMPTY=2'b00, FULL=2'b01, SKID=2'b11;
- constant PERF_CNT_W=32.
REQ-031 Counters SHALL live in one sub-module pipe_perf_cnt, instantiated only under PIPEREG_SKID_PERF_EN.

Verification
REQ-032 Streaming case: out_ready_i=1, accept 0x11,0x22,0x33 on consecutive cycles -> out_data_o shows 0x11,0x22,0x33 one cycle later each, and occ_o stays 1.
REQ-033 Backpressure case:
- Stimulus: accept 0xA0, drop out_ready_i, then accept 0xA1.
- Required: occ_o=2, in_ready_o=0, out_data_o holds 0xA0.
- Then raise out_ready_i: 0xA0 then 0xA1 fire, and in_ready_o rises the cycle after the first fire.
REQ-034 SKID with flush_i=1 and in_valid_i=1 (data 0xFF) -> next cycle state is EMPTY, out_valid_o=0, and 0xFF is never output.
REQ-035 reset_i low mid-SKID, asynchronous to clk_i -> out_valid_o=0 and occ_o=0 immediately, and out_data_o=RST_VAL.
REQ-036 PIPEREG_SKID_PERF_EN build, 5 stalled cycles then 3 idle cycles with out_ready_i=1 -> stall_cnt_o=5, bubble_cnt_o=3; a following flush_i leaves both unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and constants for the skid pipeline register
package pipe_pkg;

  // Bit 0 marks main valid, bit 1 marks skid valid, so the handshake
  // outputs decode straight from single state register bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } pipereg_state_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - downstream stall and bubble cycle counters (wrap at 2^PERF_CNT_W)
module pipe_perf_cnt
  import pipe_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] bubble_cnt_o
);

  logic [PERF_CNT_W-1:0] stall_q, stall_d;
  logic [PERF_CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (valid_i && !ready_i) stall_d = stall_q + 1'b1;
    if (!valid_i && ready_i) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: rtl/pipereg_skid.sv
// rtl/pipereg_skid.sv - registered-ready pipeline stage with skid buffer and flush
// Optional stall/bubble counters when PIPEREG_SKID_PERF_EN is defined.
module pipereg_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  input  logic                  flush_i,
`ifdef PIPEREG_SKID_PERF_EN
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] bubble_cnt_o,
`endif
  output logic [1:0]            occ_o
);

  pipereg_state_t    state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, fire;

  assign in_ready_o  = ~state_q[1];
  assign out_valid_o = state_q[0];
  assign out_data_o  = main_q;
  assign occ_o       = {state_q[1], state_q[0] & ~state_q[1]};

  assign accept = in_valid_i & in_ready_o;
  assign fire   = out_valid_o & out_ready_i;

  // Flush wins over everything; data registers keep their stale contents.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data_i;
            state_d = FULL;
          end
        end
        FULL: begin
          if (accept && fire) begin
            main_d = in_data_i;
          end else if (accept) begin
            skid_d  = in_data_i;
            state_d = SKID;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPEREG_SKID_PERF_EN
  pipe_perf_cnt u_perf (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (out_valid_o),
    .ready_i      (out_ready_i),
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipereg_skid.sv
// tb/tb_pipereg_skid.sv - randomized and directed bench for pipereg_skid against a queue model
`timescale 1ns/1ps
module tb_pipereg_skid;

  localparam int         DW   = 8;
  localparam logic [7:0] RSTV = 8'h5A;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          flush_i = 1'b0;
  logic [1:0]    occ_o;
`ifdef PIPEREG_SKID_PERF_EN
  logic [31:0]   stall_cnt_o, bubble_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq[$];
  logic [31:0]   m_stall = 0, m_bubble = 0;

  always #5 clk_i = ~clk_i;

  pipereg_skid #(.DATA_W(DW), .RST_VAL(RSTV)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .flush_i     (flush_i),
`ifdef PIPEREG_SKID_PERF_EN
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .occ_o       (occ_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two items; a flush empties it after any fire.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mq.delete();
      m_stall  <= 0;
      m_bubble <= 0;
    end else begin
      automatic bit has = (mq.size() > 0);
      automatic bit acc = in_valid_i && (mq.size() < 2);
      automatic bit fir = has && out_ready_i;
      if (has && !out_ready_i) m_stall <= m_stall + 1;
      if (!has && out_ready_i) m_bubble <= m_bubble + 1;
      if (fir) void'(mq.pop_front());
      if (flush_i) mq.delete();
      else if (acc) mq.push_back(in_data_i);
    end
  end

  always @(negedge clk_i) begin
    check("valid", {31'b0, out_valid_o}, {31'b0, mq.size() > 0});
    check("ready", {31'b0, in_ready_o}, {31'b0, mq.size() < 2});
    check("occ", {30'b0, occ_o}, mq.size());
    if (mq.size() > 0) check("data", {24'b0, out_data_o}, {24'b0, mq[0]});
`ifdef PIPEREG_SKID_PERF_EN
    check("stall_cnt", stall_cnt_o, m_stall);
    check("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid_o}, 0);
    check({tag, "_occ"}, {30'b0, occ_o}, 0);
    check({tag, "_ready"}, {31'b0, in_ready_o}, 1);
    check({tag, "_data"}, {24'b0, out_data_o}, {24'b0, RSTV});
  endtask

  int rdy_pct;

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    reset_check("rst");
    reset_i = 1'b1;

    // Streaming at full rate
    step(1, 8'h11, 1, 0);
    check("s1_data", {24'b0, out_data_o}, 32'h11);
    check("s1_occ", {30'b0, occ_o}, 1);
    step(1, 8'h22, 1, 0);
    check("s2_data", {24'b0, out_data_o}, 32'h22);
    check("s2_occ", {30'b0, occ_o}, 1);
    step(1, 8'h33, 1, 0);
    check("s3_data", {24'b0, out_data_o}, 32'h33);
    check("s3_occ", {30'b0, occ_o}, 1);
    step(0, 8'h00, 1, 0);
    check("s_drain_valid", {31'b0, out_valid_o}, 0);

    // Backpressure into the skid slot
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    check("bp_occ", {30'b0, occ_o}, 2);
    check("bp_ready", {31'b0, in_ready_o}, 0);
    check("bp_data", {24'b0, out_data_o}, 32'hA0);
    step(0, 8'h00, 0, 0);
    check("bp_hold", {24'b0, out_data_o}, 32'hA0);
    step(0, 8'h00, 1, 0);
    check("bp_second", {24'b0, out_data_o}, 32'hA1);
    check("bp_ready_up", {31'b0, in_ready_o}, 1);
    step(0, 8'h00, 1, 0);
    check("bp_empty", {31'b0, out_valid_o}, 0);

    // Flush while in SKID drops the same-cycle input
    step(1, 8'hB0, 0, 0);
    step(1, 8'hB1, 0, 0);
    step(1, 8'hFF, 0, 1);
    check("fl_valid", {31'b0, out_valid_o}, 0);
    check("fl_occ", {30'b0, occ_o}, 0);
    repeat (3) begin
      step(0, 8'h00, 1, 0);
      check("fl_no_ff", {31'b0, out_valid_o}, 0);
    end

    // Asynchronous reset in the middle of a cycle while in SKID
    step(1, 8'hC0, 0, 0);
    step(1, 8'hC1, 0, 0);
    #2 reset_i = 1'b0;
    #1 reset_check("arst");
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    step(1, 8'hC3, 1, 0);
    check("rel_valid", {31'b0, out_valid_o}, 1);
    check("rel_data", {24'b0, out_data_o}, 32'hC3);
    step(0, 8'h00, 1, 0);

`ifdef PIPEREG_SKID_PERF_EN
    reset_i = 1'b0;
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    step(1, 8'hD0, 0, 0);
    repeat (5) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    check("perf_stall", stall_cnt_o, 5);
    check("perf_bubble", bubble_cnt_o, 3);
    step(0, 8'h00, 0, 1);
    check("perf_stall_fl", stall_cnt_o, 5);
    check("perf_bubble_fl", bubble_cnt_o, 3);
`endif

    // Random traffic with varying downstream readiness
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0: rdy_pct = 90;
        1: rdy_pct = 50;
        default: rdy_pct = 10;
      endcase
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 15) == 0);
      end
    end

    step(0, 8'h00, 1, 0);
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
